// File: rtl/aes_result_collector_pkg.sv
// AESDefinitions: shared AES state/result types and the collector FSM state enum.
package AESDefinitions;
    localparam int AES_STATE_SIZE = 128;
    typedef logic [AES_STATE_SIZE-1:0] state_t;
    typedef struct packed {
        state_t     encrypt;
        state_t     plain;
        logic [3:0] encryptValid;
        logic [3:0] plainVlaid;
    } outputResult_t;
    typedef enum logic [1:0] {COL_RUN, COL_DRAIN, COL_DONE} collector_state_e;
endpackage

// File: rtl/aes_result_collector_fifo.sv
// aes_result_fifo: in-order synchronous FIFO of outputResult_t records; a push into a full FIFO is taken only alongside a pop.
module aes_result_fifo
    import AESDefinitions::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  outputResult_t              data_i,
    output outputResult_t              data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    outputResult_t mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;
    assign full_o   = count_q == CW'(DEPTH);
    assign empty_o  = count_q == '0;
    assign count_o  = count_q;
    assign do_pop   = pop_i && !empty_o;
    assign do_push  = push_i && (!full_o || do_pop);
    // Gate the head with empty so the output reads zero after reset without clearing storage.
    assign data_o   = empty_o ? '0 : mem_q[rd_ptr_q];
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge clock) begin
        if (reset && do_push) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/aes_result_collector.sv
// aes_result_collector: packs encoder/decoder captures into a result FIFO and signals end-of-message drain.
// Optional drop counter enabled by defining RESULT_DROP_COUNT_EN.
module aes_result_collector
    import AESDefinitions::*;
#(
    parameter int DEPTH        = 8,
    parameter int QUIET_CYCLES = 12
) (
    input  logic                   clock,
    input  logic                   reset,
    input  state_t                 encryptIn,
    input  logic                   encryptValidIn,
    input  state_t                 plainIn,
    input  logic                   plainValidIn,
    input  logic                   drain,
    output outputResult_t          resultOut,
    output logic                   resultValid,
    input  logic                   resultReady,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drained,
    output logic [15:0]            dropCount
);
    localparam int QW = $clog2(QUIET_CYCLES + 1);
    collector_state_e state_q, state_d;
    logic [QW-1:0]    quiet_q, quiet_d;
    logic             capture, pop, push, full, empty;
    outputResult_t    record;
    assign capture = encryptValidIn | plainValidIn;
    assign pop     = resultValid & resultReady;
    assign push    = capture && state_q != COL_DONE && (!full || pop);
    always_comb begin
        record.encrypt      = encryptValidIn ? encryptIn : '0;
        record.plain        = plainValidIn ? plainIn : '0;
        record.encryptValid = {4{encryptValidIn}};
        record.plainVlaid   = {4{plainValidIn}};
    end
    aes_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (record),
        .data_o  (resultOut),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );
    assign resultValid = !empty;
    assign drained     = state_q == COL_DONE;
    always_comb begin
        state_d = state_q;
        quiet_d = quiet_q;
        case (state_q)
            COL_RUN: begin
                if (drain) begin
                    state_d = COL_DRAIN;
                    quiet_d = '0;
                end
            end
            COL_DRAIN: begin
                if (quiet_q == QW'(QUIET_CYCLES) && count == '0) state_d = COL_DONE;
                quiet_d = capture ? '0 : (quiet_q == QW'(QUIET_CYCLES) ? quiet_q : quiet_q + QW'(1));
            end
            COL_DONE: ;
            default: state_d = COL_RUN;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= COL_RUN;
            quiet_q <= '0;
        end else begin
            state_q <= state_d;
            quiet_q <= quiet_d;
        end
    end
`ifdef RESULT_DROP_COUNT_EN
    logic        drop;
    logic [15:0] drop_q, drop_d;
    assign drop      = capture && !push;
    assign drop_d    = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    assign dropCount = drop_q;
    always_ff @(posedge clock) begin
        if (!reset) drop_q <= '0;
        else drop_q <= drop_d;
    end
`else
    assign dropCount = 16'h0000;
`endif
endmodule

// File: tb/tb_aes_result_collector.sv
// tb_aes_result_collector: directed + randomized checks of aes_result_collector against a queue-based model.
module tb_aes_result_collector;
    import AESDefinitions::*;
    localparam int DEPTH = 8;
    localparam int QC    = 12;

    logic          clock = 1'b0;
    logic          reset;
    state_t        encryptIn, plainIn;
    logic          encryptValidIn, plainValidIn, drain, resultReady;
    outputResult_t resultOut;
    logic          resultValid, drained;
    logic [3:0]    count;
    logic [15:0]   dropCount;

    aes_result_collector #(.DEPTH(DEPTH), .QUIET_CYCLES(QC)) dut (
        .clock          (clock),
        .reset          (reset),
        .encryptIn      (encryptIn),
        .encryptValidIn (encryptValidIn),
        .plainIn        (plainIn),
        .plainValidIn   (plainValidIn),
        .drain          (drain),
        .resultOut      (resultOut),
        .resultValid    (resultValid),
        .resultReady    (resultReady),
        .count          (count),
        .drained        (drained),
        .dropCount      (dropCount)
    );

    always #5 clock = ~clock;

    outputResult_t q[$];
    int drops = 0;
    int mode  = 0;
    int quiet = 0;
    int tests = 0;
    int fails = 0;

    function automatic int exp_drops();
`ifdef RESULT_DROP_COUNT_EN
        return drops;
`else
        return 0;
`endif
    endfunction

    function automatic state_t rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [263:0] obs, input logic [263:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        outputResult_t head;
        head = q.size() != 0 ? q[0] : '0;
        chk("count", count, q.size());
        chk("resultValid", resultValid, q.size() != 0);
        chk("resultOut", resultOut, head);
        chk("drained", drained, mode == 2);
        chk("dropCount", dropCount, exp_drops());
    endtask

    // Model: apply one cycle's inputs with the pre-edge view, then compare after the edge.
    task automatic step(input logic ev, input logic pv, input state_t e, input state_t p,
                        input logic rdy, input logic dr, input logic rst_n);
        outputResult_t r;
        int  pre;
        bit  cap, pp, acc;
        encryptValidIn = ev; plainValidIn = pv; encryptIn = e; plainIn = p;
        resultReady = rdy; drain = dr; reset = rst_n;
        r.encrypt = ev ? e : '0;
        r.plain = pv ? p : '0;
        r.encryptValid = {4{ev}};
        r.plainVlaid = {4{pv}};
        cap = ev | pv;
        pre = q.size();
        if (!rst_n) begin
            q.delete();
            drops = 0; mode = 0; quiet = 0;
        end else begin
            pp  = pre > 0 && rdy;
            acc = cap && mode != 2 && (pre < DEPTH || pp);
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(r);
            else if (cap && drops < 65535) drops++;
            if (mode == 0) begin
                if (dr) begin mode = 1; quiet = 0; end
            end else if (mode == 1) begin
                if (quiet == QC && pre == 0) mode = 2;
                quiet = cap ? 0 : (quiet < QC ? quiet + 1 : QC);
            end
        end
        @(posedge clock);
        @(negedge clock);
        check_all();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, '0, '0, rdy, 1'b0, 1'b1);
    endtask

    task automatic cap_rand(input logic rdy);
        step(1'b1, 1'b1, rnd128(), rnd128(), rdy, 1'b0, 1'b1);
    endtask

    initial begin
        state_t saved;
        int n;
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("reset_count", count, 0);
        chk("reset_out", resultOut, 0);

        step(1'b1, 1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 1'b1, 1'b0, 1'b1);
        chk("single_valid", resultValid, 1);
        chk("single_enc", resultOut.encrypt, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("single_plain", resultOut.plain, 128'h00112233445566778899aabbccddeeff);
        chk("single_ev", resultOut.encryptValid, 4'hF);
        chk("single_pv", resultOut.plainVlaid, 4'hF);
        idle(1'b1);
        chk("single_drained_count", count, 0);

        step(1'b1, 1'b0, rnd128(), '1, 1'b0, 1'b0, 1'b1);
        chk("enc_only_plain", resultOut.plain, 0);
        chk("enc_only_pv", resultOut.plainVlaid, 4'h0);
        chk("enc_only_ev", resultOut.encryptValid, 4'hF);
        idle(1'b1);

        for (int i = 0; i < 10; i++) cap_rand(1'b0);
        chk("fill_count", count, 8);
        chk("fill_drop", dropCount, exp_drops());
`ifdef RESULT_DROP_COUNT_EN
        chk("fill_drop_two", dropCount, 2);
`endif
        saved = rnd128();
        step(1'b1, 1'b1, saved, rnd128(), 1'b1, 1'b0, 1'b1);
        chk("full_pushpop_count", count, 8);
        for (int i = 0; i < 7; i++) idle(1'b1);
        chk("full_pushpop_last", resultOut.encrypt, saved);
        idle(1'b1);
        chk("full_empty", count, 0);

        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, rnd128(), rnd128(),
                 $urandom_range(0, 3) != 0, 1'b0, 1'b1);

        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) cap_rand(1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        chk("pre_reset_count", count, 5);
        step(1'b1, 1'b1, rnd128(), rnd128(), 1'b1, 1'b1, 1'b0);
        chk("midreset_count", count, 0);
        chk("midreset_valid", resultValid, 0);
        chk("midreset_out", resultOut, 0);
        chk("midreset_drained", drained, 0);
        chk("midreset_drop", dropCount, 0);

        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b1);
        cap_rand(1'b1);
        n = 0;
        while (n < 40 && drained !== 1'b1) begin
            idle(1'b1);
            n++;
        end
        chk("drain_latency", n, 13);
        cap_rand(1'b1);
        chk("done_drop", dropCount, exp_drops());
        for (int i = 0; i < 20; i++)
            step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rnd128(), rnd128(),
                 1'b1, $urandom_range(0, 1) == 1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/aes_result_collector.md
# aes_result_collector

Downstream stage of the bench transactor. It captures the encoder and decoder output buses whenever either valid is asserted and packs each capture into one `outputResult_t` record. Records are buffered in a small FIFO and drained to the output pipe over a valid/ready handshake. At end-of-message it runs a drain sequence so the HVL side knows all results have been delivered.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2.
- `QUIET_CYCLES`, 12, consecutive capture-free cycles required in DRAIN before DONE; ≥1.
- `clock`  in  1  sole clock, all state on posedge.
- `reset`  in  1  synchronous, active-low; sampled on posedge `clock`.
- `encryptIn`  in  `state_t` (128)  encoder output data.
- `encryptValidIn`  in  1  encoder output valid.
- `plainIn`  in  `state_t` (128)  decoder output data.
- `plainValidIn`  in  1  decoder output valid.
- `drain`  in  1  level; end-of-message seen upstream.
- `resultOut`  out  `outputResult_t` (264)  head record.
- `resultValid`  out  1  head record available.
- `resultReady`  in  1  consumer accepts head this cycle.
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `drained`  out  1  DONE reached; all records delivered.
- `dropCount`  out  16  saturating count of discarded captures.

## Operation
- **Capture:** a capture occurs in any cycle with `encryptValidIn | plainValidIn`. The record is `{encrypt=encryptIn, plain=plainIn, encryptValid={4{encryptValidIn}}, plainVlaid={4{plainValidIn}}}`. A data field whose valid is low is stored as zero.
- **Push:** the record is pushed unless the FIFO is full and no pop occurs that cycle. A full FIFO with a simultaneous pop accepts the push, so `count` is unchanged.
- **Drop:** a capture that is not pushed is dropped, and `dropCount` increments by 1, saturating at 16'hFFFF.
- **Pop:** a pop occurs when `resultValid & resultReady`. `resultValid` equals `count != 0`.
- **Ordering:** FIFO is strictly in order. Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- **FSM states:** RUN, DRAIN, DONE.
  - RUN: on `drain`=1, go to DRAIN and clear the quiet counter.
  - DRAIN: captures are still accepted. The quiet counter clears on any capture and otherwise increments, saturating at QUIET_CYCLES. The state moves to DONE when the quiet counter equals QUIET_CYCLES and `count`=0.
  - DONE: `drained`=1. Every capture is dropped and counted. The state is held until reset.
- `drain` deasserting in DRAIN or DONE has no effect.

## Timing
- **Reset values** (reset low at a posedge):
  - `count`=0, `resultValid`=0, `drained`=0, `dropCount`=0.
  - `resultOut`=0.
  - Pointers cleared, FSM=RUN, quiet counter=0.
- **Reset mid-operation:** FIFO contents are discarded without pop, and inputs in that cycle are ignored.
- **Latency:** a capture at posedge N appears on `resultOut`/`resultValid` after posedge N (visible in cycle N+1) if the FIFO was empty. No combinational input-to-output path exists.
- **Head stability:** `resultOut` holds stable while `resultValid`=1 and `resultReady`=0.
- **Throughput:** one push and one pop per cycle, sustained.
- **DRAIN to DONE:** `drained` rises on the posedge after the cycle in which the exit condition holds.

## Configuration
- `RESULT_DROP_COUNT_EN` defined: `dropCount` is implemented as above.
- `RESULT_DROP_COUNT_EN` undefined: the counter logic is compiled out and `dropCount` is tied to 16'h0000. Drop behaviour itself is unchanged.

## Structure
- `outputResult_t` moves into the shared `AESDefinitions` package, alongside `state_t` and `AES_STATE_SIZE`.
- The collector FSM state enum also goes in `AESDefinitions`.
- One sub-module, `aes_result_fifo`: parameterised synchronous FIFO (`DEPTH`, element type `outputResult_t`), with push/pop/full/empty/count.
- The FSM, capture packing and drop counter stay in `aes_result_collector`.

## Test plan
- **Single capture:** `encryptIn`=69c4e0d86a7b0430d8cdb78070b4c55a and `plainIn`=00112233445566778899aabbccddeeff, both valids=1, `resultReady`=1, one cycle.
  - Next cycle: `resultValid`=1, fields match, both valid nibbles=4'hF.
  - Following cycle: `count`=0.
- **Encoder-only capture:** `encryptValidIn`=1, `plainValidIn`=0, `plainIn`=FF..FF.
  - Record has `plain`=0 and `plainVlaid`=4'h0.
- **Fill to full:** `resultReady`=0 with 10 back-to-back captures, DEPTH=8.
  - `count`=8, `dropCount`=2.
  - Then ready=1: 8 records pop in order, first eight payloads.
- **Full with push and pop:** full FIFO, one capture with `resultReady`=1 in the same cycle.
  - `count` stays 8, `dropCount` unchanged, new record is last out.
- **Drain with late capture:** `drain` pulses, a capture arrives 5 cycles later, and the consumer pops it.
  - `drained` rises exactly 13 cycles after that capture (QUIET_CYCLES=12, plus 1).
  - A later capture increments `dropCount`.
- **Reset mid-operation:** `reset` low for one cycle with `count`=5 and `dropCount`=3.
  - Next cycle: all outputs at reset values, FSM in RUN.
